// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU, {ZF,SF,OF} condition codes and cmov/jump condition, one-cycle latency.
// One-deep output register; a stalled result (out_valid && !out_ready) holds everything and blocks intake.
module y86_execute_stage #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_icode,
  output logic [W-1:0] valE,
  output logic [W-1:0] out_valA,
  output logic         cnd,
  output logic [2:0]   cc,
  output logic         error
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [W-1:0] STACK_STEP = W'(8);

  logic         r_out_valid;
  logic [3:0]   r_out_icode;
  logic [W-1:0] r_valE;
  logic [W-1:0] r_out_valA;
  logic         r_cnd;
  logic [2:0]   r_cc;
  logic         r_error;

  logic         w_accept;
  logic [W-1:0] w_valE;
  logic         w_err;
  logic         w_cc_wr;
  logic         w_of;
  logic [2:0]   w_cc_next;
  logic         w_zf;
  logic         w_sf;
  logic         w_ovf;
  logic         w_cond;
  logic         w_cnd;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_valE  = '0;
    w_err   = 1'b0;
    w_cc_wr = 1'b0;
    w_of    = 1'b0;
    unique case (icode)
      I_HALT, I_NOP: w_valE = '0;
      I_CMOV: begin
        if (ifun > 4'd6) w_err  = 1'b1;
        else             w_valE = valA;
      end
      I_IRMOV:         w_valE = valC;
      I_RMMOV, I_MRMOV: w_valE = valB + valC;
      I_OPQ: begin
        w_cc_wr = (ifun <= 4'd3);
        unique case (ifun)
          4'd0: begin
            w_valE = valB + valA;
            w_of   = (valB[W-1] == valA[W-1]) && (w_valE[W-1] != valB[W-1]);
          end
          4'd1: begin
            w_valE = valB - valA;
            w_of   = (valB[W-1] != valA[W-1]) && (w_valE[W-1] != valB[W-1]);
          end
          4'd2:    w_valE = valB & valA;
          4'd3:    w_valE = valB ^ valA;
          default: w_err  = 1'b1;
        endcase
      end
      I_JXX: begin
        if (ifun > 4'd6) w_err = 1'b1;
      end
      I_CALL, I_PUSHQ: w_valE = valB - STACK_STEP;
      I_RET, I_POPQ:   w_valE = valB + STACK_STEP;
      default:         w_err  = 1'b1;
    endcase
  end

  assign w_cc_next = {(w_valE == '0), w_valE[W-1], w_of};

  // Conditions read the CC held before this edge, so an OPq directly ahead is already visible.
  assign w_zf  = r_cc[2];
  assign w_sf  = r_cc[1];
  assign w_ovf = r_cc[0];

  always_comb begin
    w_cond = 1'b0;
    unique case (ifun)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = (w_sf ^ w_ovf) | w_zf;
      4'd2:    w_cond = w_sf ^ w_ovf;
      4'd3:    w_cond = w_zf;
      4'd4:    w_cond = !w_zf;
      4'd5:    w_cond = !(w_sf ^ w_ovf);
      4'd6:    w_cond = !(w_sf ^ w_ovf) && !w_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_cnd = ((icode == I_CMOV) || (icode == I_JXX)) && !w_err && w_cond;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_icode <= I_NOP;
      r_valE      <= '0;
      r_out_valA  <= '0;
      r_cnd       <= 1'b0;
      r_error     <= 1'b0;
      r_cc        <= 3'b100;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_icode <= icode;
        r_valE      <= w_valE;
        r_out_valA  <= valA;
        r_cnd       <= w_cnd;
        r_error     <= w_err;
        if (w_cc_wr) r_cc <= w_cc_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_icode = r_out_icode;
  assign valE      = r_valE;
  assign out_valA  = r_out_valA;
  assign cnd       = r_cnd;
  assign cc        = r_cc;
  assign error     = r_error;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed bench for y86_execute_stage: hand-computed vectors, one sub sweep against a small reference.
module tb_y86_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [63:0] valE;
  logic [63:0] out_valA;
  logic        cnd;
  logic [2:0]  cc;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  y86_execute_stage #(.W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .valE(valE), .out_valA(out_valA), .cnd(cnd), .cc(cc), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    in_valid = 1'b1;
    icode = ic; ifun = fn; valA = a; valB = b; valC = c;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    drive(ic, fn, a, b, c);
    tick();
  endtask

  initial begin
    logic [63:0] r;
    logic [2:0]  exp_cc;
    logic [2:0]  jcnd;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0;
    tick();
    check("in_ready_in_reset", 64'(in_ready), 64'd1);
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_cc", 64'(cc), 64'h4);
    check("rst_valE", valE, 64'd0);
    check("rst_icode", 64'(out_icode), 64'h1);
    check("rst_cnd_err", {62'd0, cnd, error}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
    check("sub55_valid", 64'(out_valid), 64'd1);
    check("sub55_valE", valE, 64'd0);
    check("sub55_cc", 64'(cc), 64'h4);

    issue(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    check("add_ovf_valE", valE, 64'h8000_0000_0000_0000);
    check("add_ovf_cc", 64'(cc), 64'h3);

    issue(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
    check("sub_ovf_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
    check("sub_ovf_cc", 64'(cc), 64'h1);

    issue(4'h6, 4'h2, 64'h0F0F, 64'h00FF, 64'd0);
    check("and_valE", valE, 64'h000F);
    check("and_cc", 64'(cc), 64'h0);
    issue(4'h6, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF, 64'd0);
    check("xor_valE", valE, 64'hFFFF_FFFF_FFFF_FF00);
    check("xor_cc", 64'(cc), 64'h2);

    issue(4'h2, 4'h0, 64'h1234, 64'h9999, 64'd0);
    check("cmov_valE", valE, 64'h1234);
    check("cmov_cnd", 64'(cnd), 64'd1);
    check("cmov_valA", out_valA, 64'h1234);
    issue(4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD_BEEF);
    check("irmov_valE", valE, 64'hDEAD_BEEF);
    check("irmov_cnd", 64'(cnd), 64'd0);
    issue(4'h5, 4'h0, 64'd0, 64'h1000, 64'h20);
    check("mrmov_valE", valE, 64'h1020);
    issue(4'hB, 4'h0, 64'd0, 64'h200, 64'd0);
    check("popq_valE", valE, 64'h208);
    issue(4'h8, 4'h0, 64'd0, 64'h200, 64'd0);
    check("call_valE", valE, 64'h1F8);
    check("stack_ops_cc", 64'(cc), 64'h2);

    for (int b = 1; b <= 256; b++) begin
      for (int a = 1; a <= 256; a++) begin
        issue(4'h6, 4'h1, 64'(a), 64'(b), 64'd0);
        r = 64'(b) - 64'(a);
        exp_cc = {(r == 64'd0), r[63], 1'b0};
        check("sweep_valE", valE, r);
        check("sweep_cc", 64'(cc), 64'(exp_cc));
      end
    end

    issue(4'h6, 4'h1, 64'd7, 64'd3, 64'd0);
    check("sub37_valE", valE, 64'hFFFF_FFFF_FFFF_FFFC);
    check("sub37_cc", 64'(cc), 64'h2);
    for (int f = 1; f <= 6; f++) begin
      jcnd = 3'(f);
      issue(4'h7, 4'(f), 64'd0, 64'd0, 64'h400);
      check($sformatf("jxx_%0d_cnd", f), 64'(cnd),
            (jcnd == 3'd1 || jcnd == 3'd2 || jcnd == 3'd4) ? 64'd1 : 64'd0);
      check($sformatf("jxx_%0d_valE", f), valE, 64'd0);
    end
    issue(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    check("pushq_valE", valE, 64'hF8);
    check("pushq_cc", 64'(cc), 64'h2);

    issue(4'h6, 4'h0, 64'd20, 64'd10, 64'd0);
    check("pre_stall_valE", valE, 64'd30);
    out_ready = 1'b0;
    drive(4'h6, 4'h1, 64'd2, 64'd1, 64'd0);
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valE", valE, 64'd30);
      check("stall_cc", 64'(cc), 64'h0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready_held", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("release_valE", valE, 64'hFFFF_FFFF_FFFF_FFFF);
    check("release_cc", 64'(cc), 64'h2);
    in_valid = 1'b0;
    tick();
    check("drain_no_dup", 64'(out_valid), 64'd0);
    check("drain_cc", 64'(cc), 64'h2);

    issue(4'h6, 4'h7, 64'd1, 64'd1, 64'd0);
    check("bad_op_err", 64'(error), 64'd1);
    check("bad_op_valE", valE, 64'd0);
    check("bad_op_cc", 64'(cc), 64'h2);
    check("bad_op_valid", 64'(out_valid), 64'd1);
    issue(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
    check("bad_jxx_err_cnd", {62'd0, error, cnd}, 64'h2);
    issue(4'hC, 4'h0, 64'd0, 64'h50, 64'd0);
    check("bad_icode_err", 64'(error), 64'd1);
    check("bad_icode_valE", valE, 64'd0);
    issue(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
    check("nop_err_clear", 64'(error), 64'd0);

    rst_n = 1'b0;
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0);
    tick();
    check("rst_inflight_valid", 64'(out_valid), 64'd0);
    check("rst_inflight_cc", 64'(cc), 64'h4);
    check("rst_inflight_icode", 64'(out_icode), 64'h1);
    check("rst_inflight_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
